// File: rtl/bios_loader_pkg.sv
// Shared types and constants for the BIOS image loader.
// Holds the FSM state encoding and the default load address.
package bios_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_LO,
        CAP_LO,
        FETCH_HI,
        CAP_HI,
        WRITE,
        DONE
    } state_t;

    // Word address of the classic F000:0000 BIOS segment in a 20-bit word space.
    localparam logic [19:0] BASE_DEFAULT = 20'hF0000 >> 1;

endpackage

// File: rtl/bios_loader_packer.sv
// Byte-to-word assembly register: two source bytes are packed little-endian
// into one 16-bit write word, each half with its own load enable.
module loader_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [7:0]  byte_in,
    output logic [15:0] packed_word
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            packed_word <= '0;
        end else begin
            if (load_lo) packed_word[7:0]  <= byte_in;
            if (load_hi) packed_word[15:8] <= byte_in;
        end
    end

endmodule

// File: rtl/bios_loader.sv
// Copies a 2**AW-byte image from a sequential byte source into word memory
// at BASE, holding the CPU in reset until the whole image is written.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH_LO | strobe source for the low byte
// CAP_LO   | capture low byte
// FETCH_HI | strobe source for the high byte
// CAP_HI   | capture high byte
// WRITE    | word write pending until wr_ack
// DONE     | image loaded, terminal until reset
module bios_loader
    import bios_loader_pkg::*;
#(
    parameter int          AW   = 14,
    parameter logic [19:0] BASE = BASE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        rom_ce,
    input  logic [7:0]  rom_data,
    output logic        wr_req,
    output logic [19:0] wr_addr,
    output logic [15:0] wr_data,
    input  logic        wr_ack,
    output logic        busy,
    output logic        done,
    output logic        cpu_hold
);

    localparam int            IW       = AW - 1;
    localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic          load_lo;
    logic          load_hi;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The index stays at LAST_IDX once the final word is acknowledged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (state == WRITE && wr_ack && idx != LAST_IDX) begin
            idx <= idx + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        rom_ce     = 1'b0;
        wr_req     = 1'b0;
        wr_addr    = '0;
        load_lo    = 1'b0;
        load_hi    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = FETCH_LO;
            end
            FETCH_LO: begin
                rom_ce     = 1'b1;
                state_next = CAP_LO;
            end
            CAP_LO: begin
                load_lo    = 1'b1;
                state_next = FETCH_HI;
            end
            FETCH_HI: begin
                rom_ce     = 1'b1;
                state_next = CAP_HI;
            end
            CAP_HI: begin
                load_hi    = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                wr_req  = 1'b1;
                wr_addr = BASE + 20'(idx);
                if (wr_ack) state_next = (idx == LAST_IDX) ? DONE : FETCH_LO;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign cpu_hold = ~done;

    loader_packer u_packer (
        .clock       (clock),
        .reset       (reset),
        .load_lo     (load_lo),
        .load_hi     (load_hi),
        .byte_in     (rom_data),
        .packed_word (wr_data)
    );

endmodule

// File: tb/tb_bios_loader.sv
// Directed bench for bios_loader: a small AW=3 instance for cycle-exact
// sequences and a default-size instance for a full load with random ack delay.
module tb_bios_loader;

    localparam logic [19:0] BASE_W = 20'h78000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Small instance, AW=3
    logic        rst3, start3, ack3, ce3, req3, busy3, done3, hold3;
    logic [7:0]  data3;
    logic [19:0] addr3;
    logic [15:0] wdata3;

    bios_loader #(.AW(3)) dut3 (
        .clock(clk), .reset(rst3), .start(start3), .rom_ce(ce3), .rom_data(data3),
        .wr_req(req3), .wr_addr(addr3), .wr_data(wdata3), .wr_ack(ack3),
        .busy(busy3), .done(done3), .cpu_hold(hold3)
    );

    // Source yields bytes 01,02,... and is repositioned whenever the loader is reset.
    int ptr3;
    always @(posedge clk or posedge rst3) begin
        if (rst3) begin
            ptr3  <= 0;
            data3 <= 8'h00;
        end else if (ce3) begin
            data3 <= 8'(ptr3 + 1);
            ptr3  <= ptr3 + 1;
        end
    end

    int          ce3_n = 0;
    logic [35:0] wlog3[$];
    always @(posedge clk) begin
        if (ce3) ce3_n <= ce3_n + 1;
        if (req3 && ack3) wlog3.push_back({addr3, wdata3});
    end

    // Default instance, AW=14
    logic        rstb, startb, ackb, ceb, reqb, busyb, doneb, holdb;
    logic [7:0]  datab;
    logic [19:0] addrb;
    logic [15:0] wdatab;

    bios_loader dutb (
        .clock(clk), .reset(rstb), .start(startb), .rom_ce(ceb), .rom_data(datab),
        .wr_req(reqb), .wr_addr(addrb), .wr_data(wdatab), .wr_ack(ackb),
        .busy(busyb), .done(doneb), .cpu_hold(holdb)
    );

    int ptrb;
    always @(posedge clk or posedge rstb) begin
        if (rstb) begin
            ptrb  <= 0;
            datab <= 8'h00;
        end else if (ceb) begin
            datab <= 8'(ptrb);
            ptrb  <= ptrb + 1;
        end
    end

    int          ceb_n = 0;
    int          wrb_n = 0;
    int          done_rises = 0;
    logic        doneb_q = 1'b0;
    logic [19:0] last_ab = '0;
    logic [15:0] last_db = '0;
    always @(posedge clk) begin
        if (ceb) ceb_n <= ceb_n + 1;
        if (reqb && ackb) begin
            wrb_n   <= wrb_n + 1;
            last_ab <= addrb;
            last_db <= wdatab;
        end
        doneb_q <= doneb;
        if (doneb && !doneb_q) done_rises <= done_rises + 1;
    end

    int n0, c0, wt, dl;

    initial begin
        rst3 = 1'b1; rstb = 1'b1;
        start3 = 1'b0; startb = 1'b0;
        ack3 = 1'b0; ackb = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_rom_ce",   36'(ce3),    36'(0));
        chk("rst_wr_req",   36'(req3),   36'(0));
        chk("rst_wr_addr",  36'(addr3),  36'(0));
        chk("rst_wr_data",  36'(wdata3), 36'(0));
        chk("rst_busy",     36'(busy3),  36'(0));
        chk("rst_done",     36'(done3),  36'(0));
        chk("rst_cpu_hold", 36'(hold3),  36'(1));

        rst3 = 1'b0; rstb = 1'b0;
        @(negedge clk);

        // Full AW=3 load, ack tied high: 20 busy cycles after the start edge.
        ack3 = 1'b1;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (19) @(negedge clk);
        chk("load_done_early", 36'(done3), 36'(0));
        chk("load_busy_early", 36'(busy3), 36'(1));
        @(negedge clk);
        chk("load_done",     36'(done3), 36'(1));
        chk("load_busy_off", 36'(busy3), 36'(0));
        chk("load_hold_off", 36'(hold3), 36'(0));
        chk("load_writes",   36'(wlog3.size()), 36'(4));
        chk("load_w0", wlog3[0], {BASE_W,          16'h0201});
        chk("load_w1", wlog3[1], {BASE_W + 20'd1, 16'h0403});
        chk("load_w2", wlog3[2], {BASE_W + 20'd2, 16'h0605});
        chk("load_w3", wlog3[3], {BASE_W + 20'd3, 16'h0807});
        chk("load_ce", 36'(ce3_n), 36'(8));

        // start while in DONE is ignored
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_start_done", 36'(done3), 36'(1));
        chk("done_start_busy", 36'(busy3), 36'(0));
        chk("done_start_ce",   36'(ce3_n), 36'(8));
        chk("done_start_wr",   36'(wlog3.size()), 36'(4));

        // Ack stall on word 1 with stray acks during fetch/capture
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0; ack3 = 1'b0;
        @(negedge clk);
        n0 = wlog3.size(); c0 = ce3_n;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int i = 0; i < 20 && !req3; i++) @(negedge clk);
        chk("stall_w0_req", 36'(req3), 36'(1));
        ack3 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20 && !req3; i++) @(negedge clk);
        ack3 = 1'b0;
        chk("stall_w1_req", 36'(req3), 36'(1));
        for (int k = 0; k < 7; k++) begin
            chk("stall_req",  36'(req3),   36'(1));
            chk("stall_addr", 36'(addr3),  36'(BASE_W + 20'd1));
            chk("stall_data", 36'(wdata3), 36'(16'h0403));
            chk("stall_ce",   36'(ce3),    36'(0));
            if (k < 6) @(negedge clk);
        end
        chk("stall_ce_cnt", 36'(ce3_n - c0), 36'(4));
        ack3 = 1'b1;
        @(negedge clk);
        chk("stall_req_drop", 36'(req3), 36'(0));
        for (int i = 0; i < 40 && !done3; i++) @(negedge clk);
        chk("stall_done",   36'(done3), 36'(1));
        chk("stall_writes", 36'(wlog3.size() - n0), 36'(4));
        chk("stall_ce_tot", 36'(ce3_n - c0), 36'(8));
        chk("stall_w1", wlog3[n0 + 1], {BASE_W + 20'd1, 16'h0403});
        chk("stall_w3", wlog3[n0 + 3], {BASE_W + 20'd3, 16'h0807});

        // start while busy ignored; reset during write of word 2 aborts it
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0; ack3 = 1'b1;
        @(negedge clk);
        n0 = wlog3.size();
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int i = 0; i < 40 && !(req3 && addr3 == BASE_W + 20'd2); i++) @(negedge clk);
        chk("abort_found", 36'(req3 && addr3 == BASE_W + 20'd2), 36'(1));
        rst3 = 1'b1;
        #1;
        chk("abort_req",  36'(req3),  36'(0));
        chk("abort_busy", 36'(busy3), 36'(0));
        chk("abort_hold", 36'(hold3), 36'(1));
        chk("abort_addr", 36'(addr3), 36'(0));
        chk("abort_data", 36'(wdata3), 36'(0));
        chk("abort_writes", 36'(wlog3.size() - n0), 36'(2));
        chk("busy_start_w0", wlog3[n0],     {BASE_W,          16'h0201});
        chk("busy_start_w1", wlog3[n0 + 1], {BASE_W + 20'd1, 16'h0403});
        @(negedge clk);
        rst3 = 1'b0;
        @(negedge clk);
        n0 = wlog3.size();
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int i = 0; i < 20 && wlog3.size() == n0; i++) @(negedge clk);
        chk("restart_writes", 36'(wlog3.size() > n0), 36'(1));
        chk("restart_w0", wlog3[n0], {BASE_W, 16'h0201});

        // Full default-size load with ack delays of 0..3 cycles
        wt = 0;
        dl = int'($urandom_range(0, 3));
        startb = 1'b1;
        @(negedge clk);
        startb = 1'b0;
        for (int cyc = 0; cyc < 80000 && !doneb; cyc++) begin
            @(negedge clk);
            if (reqb) begin
                if (wt >= dl) begin
                    ackb = 1'b1;
                    wt = 0;
                    dl = int'($urandom_range(0, 3));
                end else begin
                    ackb = 1'b0;
                    wt++;
                end
            end else begin
                ackb = 1'b0;
            end
        end
        ackb = 1'b0;
        chk("big_done",      36'(doneb),   36'(1));
        chk("big_writes",    36'(wrb_n),   36'(8192));
        chk("big_last_addr", 36'(last_ab), 36'(BASE_W + 20'd8191));
        chk("big_last_data", 36'(last_db), 36'(16'hFFFE));
        chk("big_ce",        36'(ceb_n),   36'(16384));
        repeat (5) @(negedge clk);
        chk("big_done_once",  36'(done_rises), 36'(1));
        chk("big_writes_end", 36'(wrb_n),      36'(8192));
        chk("big_hold",       36'(holdb),      36'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bios_loader.md
BIOS_LOADER -- requirements
Module: bios_loader

Interface
REQ-001 Parameter AW, default 14, meaning byte-address width of the upstream source; image length is 2**AW bytes.
REQ-002 Parameter BASE, default 20'hF0000 >> 1, meaning word address of the first write (20-bit word space).
REQ-003 clock  input  1  system clock; all logic is single-clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a load when the block is idle.
REQ-006 rom_ce  output  1  advance strobe to the sequential byte source.
REQ-007 rom_data  input  8  byte from the source; valid the cycle after a rom_ce pulse.
REQ-008 wr_req  output  1  word write request to memory.
REQ-009 wr_addr  output  20  word address of the write.
REQ-010 wr_data  output  16  write data.
REQ-011 wr_ack  input  1  memory accepts the write in this cycle.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  sticky; image fully written.
REQ-014 cpu_hold  output  1  holds the CPU in reset until done.

Function
REQ-015 States SHALL be IDLE, FETCH_LO, CAP_LO, FETCH_HI, CAP_HI, WRITE, DONE.
REQ-016 IDLE->FETCH_LO on start=1; start in any other state SHALL be ignored.
REQ-017 FETCH_LO and FETCH_HI SHALL assert rom_ce for exactly one cycle, then go to CAP_LO and CAP_HI respectively.
REQ-018 CAP_LO SHALL latch rom_data into wr_data[7:0]; CAP_HI SHALL latch it into wr_data[15:8] (little-endian; first byte is low).
REQ-019 CAP_HI->WRITE with wr_req=1 from the next cycle; wr_addr = BASE + word index; the word index is AW-1 bits wide and starts at 0.
REQ-020 wr_req, wr_addr and wr_data SHALL hold stable while waiting; wr_ack with wr_req=1 completes the write, and wr_req SHALL be 0 in the following cycle.
REQ-021 On ack: if word index = 2**(AW-1)-1, go to DONE; otherwise increment the index and go to FETCH_LO.
REQ-022 wr_ack while wr_req=0 SHALL be ignored.
REQ-023 Per word: 4 cycles plus ack wait; minimum 5 cycles per word when wr_ack is tied high.
REQ-024 busy=1 in every state except IDLE and DONE; done=1 only in DONE; cpu_hold = ~done.
REQ-025 DONE is terminal until reset; the block issues no further rom_ce or wr_req.
REQ-026 rom_ce SHALL pulse exactly 2**AW times per complete load; wr_req handshakes SHALL equal 2**(AW-1).

Reset
REQ-027 Reset asserted SHALL immediately force IDLE, rom_ce=0, wr_req=0, wr_addr=0, wr_data=0, busy=0, done=0, cpu_hold=1, and word index 0.
REQ-028 Reset mid-load SHALL abort any pending write without waiting for wr_ack; the source byte pointer is not rewound by this block, so the next load after reset requires a freshly positioned source.

Structure
REQ-029 A shared package SHALL hold the state enumeration and the default BASE constant.
REQ-030 A single sub-module, loader_packer (byte-to-word assembly register with lo/hi load enables), is natural; the FSM and counter remain in bios_loader.

Verification
REQ-031 AW=3, source bytes 01..08, wr_ack tied 1, start -> writes {BASE:0201, BASE+1:0403, BASE+2:0605, BASE+3:0807}; done=1 after 20 cycles; rom_ce count 8.
REQ-032 wr_ack held 0 for 7 cycles on word 1 -> wr_req stays high with wr_addr=BASE+1 and wr_data=0403 stable for all 7 cycles; no extra rom_ce pulses.
REQ-033 Stray wr_ack pulses in FETCH/CAP states -> no state change; write count stays 4.
REQ-034 Reset asserted during WRITE of word 2 -> same-cycle wr_req=0, busy=0, cpu_hold=1; after a new start, the first write goes to BASE.
REQ-035 start pulsed while busy or in DONE -> ignored; done remains 1 and no rom_ce is issued.
REQ-036 Default AW=14 full load with random ack delays 0..3 -> 8192 writes, last wr_addr=BASE+8191, done asserted once.
